timer_setter: RTL

User-entry front end for the countdown timer mode. It turns debounced push-button levels into an hours/minutes/seconds preset, using a field-select state machine with wrap-around increment and decrement. When the user confirms, it issues a single-cycle `start` pulse and holds the preset on `hours_o`/`mins_o`/`secs_o`. These outputs drive the countdown timer's `start`, `hours_i`, `mins_i` and `secs_i` inputs directly.

---
 rtl/timer_setter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/timer_setter.sv
// Countdown-timer preset entry: turns debounced button levels into an hours/minutes/seconds
// preset through a field-select FSM, then issues a one-cycle start pulse to load the timer.
module timer_setter #(
    parameter int unsigned HRS_MAX = 23,
    parameter int unsigned MS_MAX  = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_clr,
    input  logic       btn_go,
    output logic [4:0] hours_o,
    output logic [5:0] mins_o,
    output logic [5:0] secs_o,
    output logic       start,
    output logic [1:0] field_o,
    output logic       editing
);

    localparam int unsigned HW = 5;
    localparam int unsigned MW = 6;
    localparam int unsigned NB = 5;

    localparam int unsigned B_UP   = 0;
    localparam int unsigned B_DOWN = 1;
    localparam int unsigned B_MODE = 2;
    localparam int unsigned B_CLR  = 3;
    localparam int unsigned B_GO   = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SET_H = 3'd1,
        SET_M = 3'd2,
        SET_S = 3'd3,
        LOAD  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [NB-1:0] btn;
    logic [NB-1:0] btn_q;
    logic [NB-1:0] ev;
    logic [HW-1:0] hours_nxt;
    logic [MW-1:0] mins_nxt;
    logic [MW-1:0] secs_nxt;
    logic [1:0]    field_nxt;
    logic          preset_nz;
    logic          step_up;
    logic          step_dn;

    // Wrap by comparing against the field maximum rather than relying on 2^n rollover.
    function automatic logic [MW-1:0] wrap_inc(input logic [MW-1:0] v, input logic [MW-1:0] max);
        return (v == max) ? '0 : v + MW'(1);
    endfunction

    function automatic logic [MW-1:0] wrap_dec(input logic [MW-1:0] v, input logic [MW-1:0] max);
        return (v == '0) ? max : v - MW'(1);
    endfunction

    assign btn       = {btn_go, btn_clr, btn_mode, btn_down, btn_up};
    assign ev        = btn & ~btn_q;
    assign preset_nz = |{hours_o, mins_o, secs_o};
    assign step_up   = ev[B_UP] & ~ev[B_DOWN];
    assign step_dn   = ev[B_DOWN] & ~ev[B_UP];

    // Next state and field values; only the highest-priority event (go > clr > mode > up/down) acts.
    always_comb begin
        state_nxt = state;
        hours_nxt = hours_o;
        mins_nxt  = mins_o;
        secs_nxt  = secs_o;
        unique case (state)
            IDLE: begin
                if (ev[B_GO]) begin
                    if (preset_nz) state_nxt = LOAD;
                end else if (ev[B_MODE]) begin
                    state_nxt = SET_H;
                end
            end
            SET_H, SET_M, SET_S: begin
                if (ev[B_GO]) begin
                    if (preset_nz) state_nxt = LOAD;
                end else if (ev[B_CLR]) begin
                    hours_nxt = '0;
                    mins_nxt  = '0;
                    secs_nxt  = '0;
                end else if (ev[B_MODE]) begin
                    unique case (state)
                        SET_H:   state_nxt = SET_M;
                        SET_M:   state_nxt = SET_S;
                        default: state_nxt = SET_H;
                    endcase
                end else if (step_up || step_dn) begin
                    unique case (state)
                        SET_H: hours_nxt = HW'(step_up ? wrap_inc(MW'(hours_o), MW'(HRS_MAX))
                                                       : wrap_dec(MW'(hours_o), MW'(HRS_MAX)));
                        SET_M: mins_nxt  = step_up ? wrap_inc(mins_o, MW'(MS_MAX))
                                                   : wrap_dec(mins_o, MW'(MS_MAX));
                        default: secs_nxt = step_up ? wrap_inc(secs_o, MW'(MS_MAX))
                                                    : wrap_dec(secs_o, MW'(MS_MAX));
                    endcase
                end
            end
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Field indicator follows the state being entered.
    always_comb begin
        field_nxt = 2'd0;
        unique case (state_nxt)
            SET_H:   field_nxt = 2'd1;
            SET_M:   field_nxt = 2'd2;
            SET_S:   field_nxt = 2'd3;
            default: field_nxt = 2'd0;
        endcase
    end

    // Reset reloads btn_q from the live levels so a button held through reset raises no event.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            hours_o <= '0;
            mins_o  <= '0;
            secs_o  <= '0;
            start   <= 1'b0;
            field_o <= 2'd0;
            editing <= 1'b0;
            btn_q   <= btn;
        end else begin
            state   <= state_nxt;
            hours_o <= hours_nxt;
            mins_o  <= mins_nxt;
            secs_o  <= secs_nxt;
            start   <= (state_nxt == LOAD);
            field_o <= field_nxt;
            editing <= (field_nxt != 2'd0);
            btn_q   <= btn;
        end
    end

endmodule
